barr_stream: RTL and testbench
==============================

Name: barr_stream

Overview:
- Streaming initiator around the Kyber Barrett reduction datapath (q = 3329).
- Accepts a programmed number of packed 32-bit words, each holding two signed 16-bit coefficients, over a valid/ready input stream.
- Reduces both halves through one shared reduction unit, one coefficient per cycle, and returns packed results over a valid/ready output stream.
- Sits between the coefficient buffer / DMA side and the athos accelerator result path, so whole polynomials are reduced without per-coefficient instruction issue.

Parameters:
- Q, 3329, modulus.
- V, 20159, Barrett constant, floor(2^26 / Q) rounded.
- SHIFT, 26, Barrett shift amount.
- LEN_W, 8, width of the word-count field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  start a block; sampled only in IDLE
- len_i  in  LEN_W  number of words in the block; 0 means 2^LEN_W (256)
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when high together with in_valid_i
- in_data_i  in  32  [15:0] coefficient lo, [31:16] coefficient hi, both signed
- out_valid_o  out  1  result word valid
- out_ready_i  in  1  consumer accepts the result word
- out_data_o  out  32  [15:0] reduced lo, [31:16] reduced hi, two's complement
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the last word is accepted downstream

Behaviour:
- Interface: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0. State goes to IDLE and the word counter to 0.
- Reset mid-block aborts immediately. Held and partial data are discarded and no done_o is issued.
- States: IDLE, FETCH, RED_LO, RED_HI, EMIT.
  - IDLE: start_i=1 loads the counter from len_i (0 loads 256), then goes to FETCH.
  - FETCH: in_ready_o=1. On in_valid_i, register the word and go to RED_LO. Otherwise stay.
  - RED_LO: reduce bits [15:0] into result[15:0], then go to RED_HI.
  - RED_HI: reduce bits [31:16] into result[31:16], then go to EMIT.
  - EMIT: out_valid_o=1 and out_data_o is stable. On out_ready_i, decrement the counter. If the new count is 0, go to IDLE with done_o=1 that cycle. Otherwise go to FETCH.
- Latency: input handshake in cycle N gives out_valid_o high from cycle N+3. Peak throughput is one word per 4 cycles.
- out_valid_o, once asserted, stays high with constant out_data_o until accepted.
- in_ready_o is never high in any state other than FETCH.
- start_i while busy_o=1 is ignored. Any start_i received in IDLE on the same cycle done_o rises is not honoured.
- Arithmetic, with a the signed 16-bit coefficient:
  - t = (a*V + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at ≥32 bits.
  - r = a − t*Q.
  - r is the centred representative in [−1664, 1664], written as 16-bit two's complement.
- The block holds only the single datapath, so all intermediate products must use signed arithmetic wide enough to be exact for a in [−32768, 32767].

Optional Feature:
- Macro: BARR_STREAM_CANON_EN.
- When defined, after r is computed, Q is added if r < 0, giving the canonical range [0, 3328]. Latency is unchanged: the correction stays inside the RED_LO / RED_HI cycle.
- When undefined, output is the centred range [−1664, 1664].

Test Plan:
- Reset, then start_i with len_i=1 and input 0x0D01_F2FF (hi=3329, lo=−3329) → out_data_o=0x0000_0000; out_valid_o 3 cycles after the input handshake; done_o pulses on acceptance.
- Input hi=32767, lo=−32768 (0x7FFF_8000) → 0xFDF5_020A (−523, 522). With BARR_STREAM_CANON_EN: 0x0AF6_020A (2806, 522).
- Boundary: hi=1664, lo=1665 (0x0680_0681) → 0x0680_F980 (1664, −1664). With canon: lo=0x0681 (1665).
- len_i=0 with in_valid_i held high and out_ready_i tied high → exactly 256 output words, done_o once, busy_o low the cycle after; start_i pulsed mid-block has no effect.
- Backpressure: out_ready_i low for 10 cycles in EMIT → out_valid_o and out_data_o held constant, in_ready_o=0 throughout, no word lost or duplicated.
- rst_i asserted in RED_HI of word 3 of a 5-word block → next cycle all outputs 0, IDLE, no done_o; a new start_i with len_i=2 then completes normally.

Source files
------------

// File: rtl/barr_stream.sv
// ---------------------------------------------------------------------------
// barr_stream
//
// Streaming wrapper around a Kyber Barrett reduction datapath (q = 3329).
// A block of len_i packed words is pulled from the input stream. Each word
// carries two signed 16-bit coefficients. Both coefficients go through one
// shared reduction unit, one per cycle, and the packed result is pushed to
// the output stream.
//
// Optional build macro:
//   BARR_STREAM_CANON_EN  - fold negative results up by Q, giving the
//                           canonical range [0, 3328] instead of [-1664, 1664].
//
// Handshake rule (both streams): a word moves on a rising clock edge where
// valid and ready are both high. Once out_valid_o is raised, it stays high
// and out_data_o stays constant until the word is accepted.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   start_i      start a block (sampled in IDLE only)
//   len_i        words in the block; 0 selects 2^LEN_W
//   in_valid_i   input word valid
//   in_ready_o   input word ready (high only in FETCH)
//   in_data_i    {coef_hi, coef_lo}, signed 16-bit each
//   out_valid_o  result word valid (high only in EMIT)
//   out_ready_i  result word accepted
//   out_data_o   {red_hi, red_lo}, two's complement
//   busy_o       high whenever the FSM is not in IDLE
//   done_o       one-cycle pulse after the last word is accepted downstream
// ---------------------------------------------------------------------------
module barr_stream #(
    parameter int Q     = 3329,
    parameter int V     = 20159,
    parameter int SHIFT = 26,
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        RED_LO = 3'd2,
        RED_HI = 3'd3,
        EMIT   = 3'd4
    } state_t;

    // One extra bit so the count can hold 2^LEN_W.
    localparam int CNT_W = LEN_W + 1;

    localparam logic signed [31:0] Q_S   = 32'(Q);
    localparam logic signed [31:0] V_S   = 32'(V);
    localparam logic signed [31:0] RND_S = 32'sd1 <<< (SHIFT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        word_q,  word_d;
    logic [31:0]        res_q,   res_d;
    logic               done_q,  done_d;

    logic [15:0]        red_in;
    logic [15:0]        red_out;

    // Barrett reduction of one signed 16-bit coefficient. |a*V| stays below
    // 2^30, so 32-bit signed arithmetic is exact for every 16-bit input.
    function automatic logic [15:0] barrett(input logic [15:0] a_raw);
        logic signed [31:0] a;
        logic signed [31:0] prod;
        logic signed [31:0] t;
        logic signed [31:0] r;
        a    = $signed({{16{a_raw[15]}}, a_raw});
        prod = a * V_S;
        t    = (prod + RND_S) >>> SHIFT;
        r    = a - t * Q_S;
`ifdef BARR_STREAM_CANON_EN
        if (r < 0) begin
            r = r + Q_S;
        end
`endif
        return r[15:0];
    endfunction

    // The shared reduction unit: lo half in RED_LO, hi half in RED_HI.
    assign red_in  = (state_q == RED_HI) ? word_q[31:16] : word_q[15:0];
    assign red_out = barrett(red_in);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        res_d   = res_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // done_q high means the previous block finished on the last
                // edge; a start arriving in that same cycle is dropped.
                if (start_i && !done_q) begin
                    cnt_d   = (len_i == '0) ? CNT_W'(1 << LEN_W)
                                            : {1'b0, len_i};
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (in_valid_i) begin
                    word_d  = in_data_i;
                    state_d = RED_LO;
                end
            end
            RED_LO: begin
                res_d[15:0] = red_out;
                state_d     = RED_HI;
            end
            RED_HI: begin
                res_d[31:16] = red_out;
                state_d      = EMIT;
            end
            EMIT: begin
                if (out_ready_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready_o  = (state_q == FETCH);
    assign out_valid_o = (state_q == EMIT);
    assign out_data_o  = res_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_barr_stream.sv
// ---------------------------------------------------------------------------
// tb_barr_stream
//
// Directed bench for barr_stream. Inputs change on the falling edge, and
// outputs are sampled on the falling edge, half a cycle away from the
// active rising edge.
// ---------------------------------------------------------------------------
module tb_barr_stream;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  len_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed vectors: input words and their reduced results.
    localparam logic [31:0] IN_ZERO  = 32'h0D01_F2FF;  // hi=3329, lo=-3329
    localparam logic [31:0] IN_EXTR  = 32'h7FFF_8000;  // hi=32767, lo=-32768
    localparam logic [31:0] IN_BND   = 32'h0680_0681;  // hi=1664, lo=1665
    localparam logic [31:0] EXP_ZERO = 32'h0000_0000;
`ifdef BARR_STREAM_CANON_EN
    localparam logic [31:0] EXP_EXTR = 32'h0AF6_020A;  // 2806, 522
    localparam logic [31:0] EXP_BND  = 32'h0680_0681;  // 1664, 1665
`else
    localparam logic [31:0] EXP_EXTR = 32'hFDF5_020A;  // -523, 522
    localparam logic [31:0] EXP_BND  = 32'h0680_F980;  // 1664, -1664
`endif

    logic [31:0] vec_in  [3];
    logic [31:0] vec_exp [3];

    barr_stream dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic start_block(input logic [7:0] len);
        @(negedge clk_i);
        start_i = 1'b1;
        len_i   = len;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Send one word, check latency, hold off the consumer for 'hold' cycles,
    // then accept. When 'last' is set, check the done pulse afterwards.
    task automatic process_word(input string tag, input logic [31:0] din,
                                input logic [31:0] exp, input int hold,
                                input bit last);
        int guard;
        guard = 0;
        while (!in_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        in_data_i  = din;
        @(negedge clk_i);                       // cycle N+1
        in_valid_i = 1'b0;
        in_data_i  = 32'hDEAD_BEEF;
        chk({tag, "_lat1_valid"}, 32'(out_valid_o), 32'd0);
        @(negedge clk_i);                       // cycle N+2
        chk({tag, "_lat2_valid"}, 32'(out_valid_o), 32'd0);
        @(negedge clk_i);                       // cycle N+3
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, "_data"}, out_data_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_hold_valid"}, 32'(out_valid_o), 32'd1);
            chk({tag, "_hold_data"}, out_data_o, exp);
            chk({tag, "_hold_in_ready"}, 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        chk({tag, "_done"}, 32'(done_o), 32'(last));
        chk({tag, "_busy_after"}, 32'(busy_o), 32'(!last));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int out_cnt, in_cnt, done_cnt, cyc;

        vec_in[0]  = IN_ZERO;  vec_exp[0] = EXP_ZERO;
        vec_in[1]  = IN_EXTR;  vec_exp[1] = EXP_EXTR;
        vec_in[2]  = IN_BND;   vec_exp[2] = EXP_BND;

        rst_i       = 1'b1;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_in_ready",  32'(in_ready_o),  32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_data",  out_data_o,       32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_done",      32'(done_o),      32'd0);
        rst_i = 1'b0;

        // Single word, +/-Q reduce to zero
        start_block(8'd1);
        chk("t1_busy", 32'(busy_o), 32'd1);
        process_word("t1", IN_ZERO, EXP_ZERO, 0, 1'b1);
        // A start in the done cycle must be ignored.
        start_i = 1'b1;
        len_i   = 8'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("t1_start_in_done_busy", 32'(busy_o), 32'd0);
        chk("t1_done_cleared", 32'(done_o), 32'd0);

        // Three-word block: extremes, boundary with backpressure, zero
        start_block(8'd3);
        process_word("t2_extr", IN_EXTR, EXP_EXTR, 0, 1'b0);
        process_word("t2_bnd",  IN_BND,  EXP_BND, 10, 1'b0);
        process_word("t2_zero", IN_ZERO, EXP_ZERO, 0, 1'b1);

        // len 0 = 256 words, streaming at full rate
        start_block(8'd0);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        out_cnt  = 0;
        in_cnt   = 0;
        done_cnt = 0;
        cyc      = 0;
        while (done_cnt == 0 && cyc < 1200) begin
            if (out_valid_o) begin
                chk("t3_data", out_data_o, vec_exp[out_cnt % 3]);
                out_cnt++;
            end
            in_data_i = vec_in[in_cnt % 3];
            if (in_ready_o) in_cnt++;
            start_i = (cyc == 100);
            len_i   = 8'd4;
            @(negedge clk_i);
            cyc++;
            if (done_o) begin
                done_cnt++;
                chk("t3_busy_at_done", 32'(busy_o), 32'd0);
            end
        end
        chk("t3_timeout", 32'(cyc < 1200), 32'd1);
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("t3_out_count", 32'(out_cnt), 32'd256);
        chk("t3_in_count", 32'(in_cnt), 32'd256);
        chk("t3_done_count", 32'(done_cnt), 32'd1);
        chk("t3_idle_in_ready", 32'(in_ready_o), 32'd0);
        chk("t3_idle_busy", 32'(busy_o), 32'd0);

        // Reset in RED_HI of word 3 of a 5-word block
        start_block(8'd5);
        process_word("t4_w1", IN_EXTR, EXP_EXTR, 0, 1'b0);
        process_word("t4_w2", IN_BND,  EXP_BND,  0, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = IN_EXTR;
        @(negedge clk_i);                       // RED_LO
        in_valid_i = 1'b0;
        @(negedge clk_i);                       // RED_HI
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("t4_rst_in_ready",  32'(in_ready_o),  32'd0);
        chk("t4_rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("t4_rst_out_data",  out_data_o,       32'd0);
        chk("t4_rst_busy",      32'(busy_o),      32'd0);
        chk("t4_rst_done",      32'(done_o),      32'd0);
        @(negedge clk_i);
        chk("t4_no_done_late",  32'(done_o),      32'd0);

        // Fresh 2-word block after the abort
        start_block(8'd2);
        process_word("t5_w1", IN_BND,  EXP_BND,  0, 1'b0);
        process_word("t5_w2", IN_ZERO, EXP_ZERO, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
